// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the issue controller: instruction field layout, function
// encodings, source-register decode helpers and the issue FSM state type.
// Instruction word layout: {func[23:20], rs1[19:16], rs2[15:12], rd[11:8], addr[7:0]}.
package pipe_pkg;

    localparam int unsigned INSTR_W  = 24;
    localparam int unsigned FUNC_W   = 4;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned ADDR_W   = 8;

    localparam int unsigned FUNC_LSB = 20;
    localparam int unsigned RS1_LSB  = 16;
    localparam int unsigned RS2_LSB  = 12;
    localparam int unsigned RD_LSB   = 8;
    localparam int unsigned ADDR_LSB = 0;

    localparam logic [FUNC_W-1:0] FUNC_ADD = 4'd0;
    localparam logic [FUNC_W-1:0] FUNC_SUB = 4'd1;
    localparam logic [FUNC_W-1:0] FUNC_AND = 4'd2;
    localparam logic [FUNC_W-1:0] FUNC_NOT = 4'd3;
    localparam logic [FUNC_W-1:0] FUNC_MOV = 4'd4;
    localparam logic [FUNC_W-1:0] FUNC_OR  = 4'd5;
    localparam logic [FUNC_W-1:0] FUNC_XOR = 4'd6;
    localparam logic [FUNC_W-1:0] FUNC_CMP = 4'd7;
    localparam logic [FUNC_W-1:0] FUNC_LD  = 4'd8;
    localparam logic [FUNC_W-1:0] FUNC_ST  = 4'd9;
    localparam logic [FUNC_W-1:0] FUNC_SHR = 4'd10;
    localparam logic [FUNC_W-1:0] FUNC_SHL = 4'd11;

    // Every encoding at or above this value is dropped as illegal.
    localparam logic [FUNC_W-1:0] FUNC_ILLEGAL_MIN = 4'd12;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StHeld
    } state_e;

    function automatic logic uses_rs1(input logic [FUNC_W-1:0] func);
        logic r;
        case (func)
            FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_CMP,
            FUNC_NOT, FUNC_LD, FUNC_SHR, FUNC_SHL: r = 1'b1;
            default:                               r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic uses_rs2(input logic [FUNC_W-1:0] func);
        logic r;
        case (func)
            FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_CMP,
            FUNC_MOV, FUNC_ST: r = 1'b1;
            default:           r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// issue_fifo
// Synchronous FIFO holding encoded instructions ahead of issue. The head entry is
// presented combinationally on o_head; o_empty qualifies it.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_push, i_wdata     write request and data (ignored when full or flushing)
//   i_pop               remove head entry (ignored when empty or flushing)
//   i_flush             discard every stored entry
//   o_full, o_empty     occupancy status
//   o_head              data of the oldest entry
module issue_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    // DEPTH is a power of two, so the pointers wrap naturally.
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_cnt;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_head    = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// pipe_issue_ctrl
// Buffers host instructions and issues at most one per clock into pipeline stage 1.
// Heads whose used source registers are still being written by an in-flight
// instruction stall; illegal function codes are dropped with a one-cycle error pulse.
// A level drain request stops intake, lets queued work issue and reports drained once
// the queue is empty and no producer remains in the hazard window.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid, in_instr       host instruction; in_ready accepts it
//   flush                    discard queued, unissued instructions
//   drain, drained           quiesce request / quiesced status
//   iss_valid, iss_*         registered issue strobe and fields
//   stall, err_illegal       registered hazard-hold and illegal-drop indications
//   issue_cnt, stall_cnt     saturating statistics
// Build option: define PIPE_ISSUE_STATS_EN to enable the statistics counters;
// otherwise both counter ports are tied to zero.
module pipe_issue_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned HAZ_WIN = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    input  logic               flush,
    input  logic               drain,
    output logic               drained,
    output logic               iss_valid,
    output logic [REG_W-1:0]   iss_rs1,
    output logic [REG_W-1:0]   iss_rs2,
    output logic [REG_W-1:0]   iss_rd,
    output logic [FUNC_W-1:0]  iss_func,
    output logic [ADDR_W-1:0]  iss_addr,
    output logic               stall,
    output logic               err_illegal,
    output logic [15:0]        issue_cnt,
    output logic [15:0]        stall_cnt
);

    state_e w_state_nxt;
    state_e r_state;

    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [INSTR_W-1:0] w_head;
    logic               w_push;
    logic               w_pop;
    logic               w_issue;
    logic               w_stall;
    logic               w_drop;

    logic [FUNC_W-1:0]  w_head_func;
    logic [REG_W-1:0]   w_head_rs1;
    logic [REG_W-1:0]   w_head_rs2;
    logic [REG_W-1:0]   w_head_rd;
    logic [ADDR_W-1:0]  w_head_addr;
    logic               w_illegal;
    logic               w_hazard;

    logic               r_sb_vld [HAZ_WIN];
    logic [REG_W-1:0]   r_sb_rd  [HAZ_WIN];
    logic [HAZ_WIN-1:0] w_sb_vld;
    logic [HAZ_WIN-1:0] w_sb_hit;
    logic               w_sb_clear;

    logic               r_iss_valid;
    logic [REG_W-1:0]   r_iss_rs1;
    logic [REG_W-1:0]   r_iss_rs2;
    logic [REG_W-1:0]   r_iss_rd;
    logic [FUNC_W-1:0]  r_iss_func;
    logic [ADDR_W-1:0]  r_iss_addr;
    logic               r_stall;
    logic               r_err;

    // ---------------------------------------------------------------- instruction queue
    assign w_push = in_valid && in_ready;

    issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_wdata (in_instr),
        .i_pop   (w_pop),
        .i_flush (flush),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_head)
    );

    assign w_head_func = w_head[FUNC_LSB +: FUNC_W];
    assign w_head_rs1  = w_head[RS1_LSB +: REG_W];
    assign w_head_rs2  = w_head[RS2_LSB +: REG_W];
    assign w_head_rd   = w_head[RD_LSB +: REG_W];
    assign w_head_addr = w_head[ADDR_LSB +: ADDR_W];
    assign w_illegal   = (w_head_func >= FUNC_ILLEGAL_MIN);

    // ---------------------------------------------------------------- scoreboard
    // Slot 0 holds the instruction issued at the last edge; older producers shift up
    // and fall off after HAZ_WIN cycles, when their result is in the regbank.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb_vld[0] <= 1'b0;
            r_sb_rd[0]  <= '0;
        end else begin
            r_sb_vld[0] <= w_issue;
            r_sb_rd[0]  <= w_head_rd;
        end
    end

    for (genvar g = 1; g < HAZ_WIN; g++) begin : g_sb_shift
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sb_vld[g] <= 1'b0;
                r_sb_rd[g]  <= '0;
            end else begin
                r_sb_vld[g] <= r_sb_vld[g-1];
                r_sb_rd[g]  <= r_sb_rd[g-1];
            end
        end
    end

    for (genvar g = 0; g < HAZ_WIN; g++) begin : g_sb_cmp
        assign w_sb_vld[g] = r_sb_vld[g];
        assign w_sb_hit[g] = r_sb_vld[g] &&
                             ((uses_rs1(w_head_func) && (r_sb_rd[g] == w_head_rs1)) ||
                              (uses_rs2(w_head_func) && (r_sb_rd[g] == w_head_rs2)));
    end

    assign w_hazard   = |w_sb_hit;
    assign w_sb_clear = ~|w_sb_vld;

    // ---------------------------------------------------------------- head handling
    always_comb begin
        w_pop   = 1'b0;
        w_issue = 1'b0;
        w_stall = 1'b0;
        w_drop  = 1'b0;
        if (!w_fifo_empty && !flush) begin
            if (w_illegal) begin
                w_pop  = 1'b1;
                w_drop = 1'b1;
            end else if (w_hazard) begin
                w_stall = 1'b1;
            end else begin
                w_pop   = 1'b1;
                w_issue = 1'b1;
            end
        end
    end

    // Issue fields hold their last value between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss_valid <= 1'b0;
            r_iss_rs1   <= '0;
            r_iss_rs2   <= '0;
            r_iss_rd    <= '0;
            r_iss_func  <= '0;
            r_iss_addr  <= '0;
            r_stall     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_iss_valid <= w_issue;
            r_stall     <= w_stall;
            r_err       <= w_drop;
            if (w_issue) begin
                r_iss_rs1  <= w_head_rs1;
                r_iss_rs2  <= w_head_rs2;
                r_iss_rd   <= w_head_rd;
                r_iss_func <= w_head_func;
                r_iss_addr <= w_head_addr;
            end
        end
    end

    assign iss_valid   = r_iss_valid;
    assign iss_rs1     = r_iss_rs1;
    assign iss_rs2     = r_iss_rs2;
    assign iss_rd      = r_iss_rd;
    assign iss_func    = r_iss_func;
    assign iss_addr    = r_iss_addr;
    assign stall       = r_stall;
    assign err_illegal = r_err;

    // ---------------------------------------------------------------- drain FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StRun: begin
                if (drain) begin
                    w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                if (!drain) begin
                    w_state_nxt = StRun;
                end else if (w_fifo_empty && w_sb_clear) begin
                    w_state_nxt = StHeld;
                end
            end
            StHeld: begin
                if (!drain) begin
                    w_state_nxt = StRun;
                end
            end
            default: w_state_nxt = StRun;
        endcase
    end

    always_comb begin
        in_ready = !rst && !w_fifo_full && !flush && (r_state == StRun);
        drained  = (r_state == StHeld);
    end

    // ---------------------------------------------------------------- statistics
`ifdef PIPE_ISSUE_STATS_EN
    logic [15:0] r_issue_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_issue && (r_issue_cnt != 16'hFFFF)) begin
                r_issue_cnt <= r_issue_cnt + 16'd1;
            end
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign issue_cnt = r_issue_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    assign issue_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// tb_pipe_issue_ctrl
// Directed bench for pipe_issue_ctrl: a single linear sequence of steps, each followed
// by immediate-assertion checks against hand-computed values.
module tb_pipe_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [23:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        drain;
    logic        drained;
    logic        iss_valid;
    logic [3:0]  iss_rs1;
    logic [3:0]  iss_rs2;
    logic [3:0]  iss_rd;
    logic [3:0]  iss_func;
    logic [7:0]  iss_addr;
    logic        stall;
    logic        err_illegal;
    logic [15:0] issue_cnt;
    logic [15:0] stall_cnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

`ifdef PIPE_ISSUE_STATS_EN
    localparam int unsigned EXP_ISSUES = 15;
    localparam int unsigned EXP_STALLS = 7;
`else
    localparam int unsigned EXP_ISSUES = 0;
    localparam int unsigned EXP_STALLS = 0;
`endif

    pipe_issue_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .flush       (flush),
        .drain       (drain),
        .drained     (drained),
        .iss_valid   (iss_valid),
        .iss_rs1     (iss_rs1),
        .iss_rs2     (iss_rs2),
        .iss_rd      (iss_rd),
        .iss_func    (iss_func),
        .iss_addr    (iss_addr),
        .stall       (stall),
        .err_illegal (err_illegal),
        .issue_cnt   (issue_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] mk(input logic [3:0] f, input logic [3:0] s1,
                                       input logic [3:0] s2, input logic [3:0] d,
                                       input logic [7:0] a);
        return {f, s1, s2, d, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 2 time units after the active edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [23:0] instr);
        in_valid = 1'b1;
        in_instr = instr;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_instr = '0;
    endtask

    task automatic chk_iss(input string tag, input logic [3:0] rd, input logic [7:0] addr);
        chk({tag, ".valid"}, iss_valid, 1);
        chk({tag, ".rd"}, iss_rd, rd);
        chk({tag, ".addr"}, iss_addr, addr);
        chk({tag, ".stall"}, stall, 0);
    endtask

    task automatic chk_none(input string tag, input logic exp_stall);
        chk({tag, ".valid"}, iss_valid, 0);
        chk({tag, ".stall"}, stall, exp_stall);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; drain = 1'b0;
        step(); step();

        // Reset state
        chk("rst.in_ready", in_ready, 0);
        chk("rst.iss_valid", iss_valid, 0);
        chk("rst.stall", stall, 0);
        chk("rst.err", err_illegal, 0);
        chk("rst.drained", drained, 0);
        chk("rst.iss_rd", iss_rd, 0);
        chk("rst.issue_cnt", issue_cnt, 0);
        chk("rst.stall_cnt", stall_cnt, 0);
        rst = 1'b0;
        #1;
        chk("post_rst.in_ready", in_ready, 1);

        // Independent stream: one issue per cycle, first one edge after its push
        push(mk(4'd0, 4'd3, 4'd5, 4'd10, 8'd125)); step();
        chk("t1.latency", iss_valid, 0);
        push(mk(4'd2, 4'd3, 4'd8, 4'd12, 8'd126)); step();
        chk_iss("t1.a", 4'd10, 8'd125);
        chk("t1.a.rs1", iss_rs1, 3);
        chk("t1.a.rs2", iss_rs2, 5);
        push(mk(4'd7, 4'd1, 4'd2, 4'd4, 8'd127)); step();
        chk_iss("t1.b", 4'd12, 8'd126);
        chk("t1.b.func", iss_func, 2);
        idle(); step();
        chk_iss("t1.c", 4'd4, 8'd127);
        chk("t1.c.func", iss_func, 7);
        step();
        chk_none("t1.end", 1'b0);
        step(); step();

        // RAW hazard: consumer stalls twice, issues 3 edges after producer
        push(mk(4'd0, 4'd3, 4'd5, 4'd10, 8'd1)); step();
        push(mk(4'd1, 4'd10, 4'd5, 4'd14, 8'd2)); step();
        chk_iss("t2.prod", 4'd10, 8'd1);
        idle(); step();
        chk_none("t2.stall1", 1'b1);
        step();
        chk_none("t2.stall2", 1'b1);
        step();
        chk_iss("t2.cons", 4'd14, 8'd2);
        step();
        chk_none("t2.end", 1'b0);
        step(); step();

        // rs2-only consumer of rd is exempt through rs1
        push(mk(4'd0, 4'd3, 4'd5, 4'd10, 8'd3)); step();
        push(mk(4'd4, 4'd10, 4'd6, 4'd13, 8'd4)); step();
        chk_iss("t3.prod", 4'd10, 8'd3);
        idle(); step();
        chk_iss("t3.mov", 4'd13, 8'd4);
        step(); step(); step();

        // Illegal func dropped, following legal instruction issues next cycle
        push(mk(4'd13, 4'd1, 4'd2, 4'd3, 8'd5)); step();
        chk("t4.err_pre", err_illegal, 0);
        push(mk(4'd0, 4'd1, 4'd2, 4'd6, 8'd6)); step();
        chk("t4.err", err_illegal, 1);
        chk_none("t4.drop", 1'b0);
        idle(); step();
        chk_iss("t4.legal", 4'd6, 8'd6);
        chk("t4.err_once", err_illegal, 0);
        step(); step(); step();

        // Fill behind a stalled head, then flush with a push attempt
        push(mk(4'd0, 4'd1, 4'd2, 4'd9, 8'h10)); step();
        push(mk(4'd0, 4'd9, 4'd9, 4'd7, 8'h11)); step();
        chk_iss("t5.x", 4'd9, 8'h10);
        push(mk(4'd0, 4'd7, 4'd7, 4'd8, 8'h12)); step();
        chk_none("t5.stall1", 1'b1);
        push(mk(4'd0, 4'd1, 4'd1, 4'd1, 8'h13)); step();
        chk_none("t5.stall2", 1'b1);
        push(mk(4'd0, 4'd2, 4'd2, 4'd2, 8'h14)); step();
        chk_iss("t5.y", 4'd7, 8'h11);
        push(mk(4'd0, 4'd3, 4'd3, 4'd3, 8'h15)); step();
        chk_none("t5.stall3", 1'b1);
        chk("t5.full", in_ready, 0);
        flush = 1'b1;
        push(mk(4'd0, 4'd4, 4'd4, 4'd4, 8'h16));
        step();
        chk_none("t5.flush", 1'b0);
        flush = 1'b0;
        idle();
        #1;
        chk("t5.ready_after_flush", in_ready, 1);
        step();
        chk_none("t5.discarded", 1'b0);
        push(mk(4'd0, 4'd7, 4'd7, 4'd5, 8'h17)); step();
        idle(); step();
        chk_iss("t5.aged", 4'd5, 8'h17);
        step(); step();

        // Drain with three queued, then reset while held
        push(mk(4'd0, 4'd1, 4'd1, 4'd11, 8'h20)); step();
        push(mk(4'd0, 4'd11, 4'd11, 4'd12, 8'h21)); step();
        chk_iss("t6.p0", 4'd11, 8'h20);
        push(mk(4'd0, 4'd3, 4'd3, 4'd13, 8'h22)); step();
        chk_none("t6.stall1", 1'b1);
        push(mk(4'd6, 4'd4, 4'd4, 4'd14, 8'h23)); step();
        chk_none("t6.stall2", 1'b1);
        idle();
        drain = 1'b1;
        step();
        chk_iss("t6.d1", 4'd12, 8'h21);
        chk("t6.ready_drain", in_ready, 0);
        step();
        chk_iss("t6.d2", 4'd13, 8'h22);
        chk("t6.drained_early", drained, 0);
        step();
        chk_iss("t6.d3", 4'd14, 8'h23);
        step();
        chk_none("t6.idle", 1'b0);
        chk("t6.drained_win1", drained, 0);
        step();
        chk("t6.drained_win2", drained, 0);
        step();
        chk("t6.drained", drained, 1);
        chk("t6.ready_held", in_ready, 0);
        chk("t6.issue_cnt", issue_cnt, EXP_ISSUES);
        chk("t6.stall_cnt", stall_cnt, EXP_STALLS);
        rst = 1'b1;
        #1;
        chk("t6.rst_ready", in_ready, 0);
        step();
        chk("t6.rst.drained", drained, 0);
        chk("t6.rst.iss_valid", iss_valid, 0);
        chk("t6.rst.iss_rd", iss_rd, 0);
        chk("t6.rst.iss_func", iss_func, 0);
        chk("t6.rst.iss_addr", iss_addr, 0);
        chk("t6.rst.issue_cnt", issue_cnt, 0);
        rst = 1'b0;
        drain = 1'b0;
        #1;
        chk("t6.run_ready", in_ready, 1);
        push(mk(4'd5, 4'd1, 4'd2, 4'd3, 8'h44)); step();
        idle(); step();
        chk_iss("t6.after_rst", 4'd3, 8'h44);
        chk("t6.after_rst.func", iss_func, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
